// File: rtl/aes_package.sv
// aes_package: shared constants and FSM state type for the AES block gatherer.
package aes_package;
  localparam int BEATS = 4;
  localparam int BLK_W = 128;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;
endpackage

// File: rtl/aes_block_gather_buf.sv
// aes_gather_buf: 128-bit word-indexed load register; valid rises when the last beat lands.
module aes_gather_buf
  import aes_package::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [1:0]        idx_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              take_i,
  output logic [BLK_W-1:0]  data_o,
  output logic              vld_o
);
  logic [BLK_W-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < BEATS; k++)
      if (load_i && idx_i == 2'(k)) data_d[BLK_W-1-WORD_W*k -: WORD_W] = word_i;
    vld_d = !clr_i && !take_i && (vld_q || (load_i && idx_i == 2'(BEATS-1)));
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  assign data_o = data_q;
  assign vld_o  = vld_q;
endmodule

// File: rtl/aes_block_gather.sv
// aes_block_gather: packs 32-bit beats into 128-bit blocks for the cipher core.
// Define AES_GATHER_SKID_EN for a second buffer so filling overlaps a held block.
module aes_block_gather
  import aes_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [BLK_W-1:0]  blk_data_o,
  output logic              blk_valid_o,
  input  logic              blk_ready_i,
  output logic              blk_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_cnt_o
);
`ifdef AES_GATHER_SKID_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d, gath_q, gath_d;
  logic [1:0]       beat_q, beat_d, held_n;
  logic             done_q, done_d;
  logic             wr, rd, acc, fin, hs;
  logic [BLK_W-1:0] buf_data [2];
  logic             buf_vld [2];
`ifdef AES_GATHER_SKID_EN
  logic wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = clear_i ? 1'b0 : wr_q ^ fin;
    rd_d = clear_i ? 1'b0 : rd_q ^ hs;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  assign wr = wr_q;
  assign rd = rd_q;
`else
  assign wr = 1'b0;
  assign rd = 1'b0;
`endif
  for (genvar g = 0; g < 2; g++) begin : g_buf
    if (g < NB) begin : g_inst
      aes_gather_buf u_buf (
        .clk_i,
        .rst_i,
        .clr_i  (clear_i),
        .load_i (acc && wr == 1'(g)),
        .idx_i  (beat_q),
        .word_i (in_data_i),
        .take_i (hs && rd == 1'(g)),
        .data_o (buf_data[g]),
        .vld_o  (buf_vld[g])
      );
    end else begin : g_none
      assign buf_data[g] = '0;
      assign buf_vld[g]  = 1'b0;
    end
  end
  assign busy_o      = state_q != IDLE;
  // gath_q stops intake once every block of the job has been gathered
  assign in_ready_o  = busy_o && gath_q != len_q && !buf_vld[wr];
  assign blk_valid_o = buf_vld[rd];
  assign blk_data_o  = buf_data[rd];
  assign blk_last_o  = blk_valid_o && (cnt_q + CNT_W'(1) == len_q);
  assign done_o      = done_q;
  assign blk_cnt_o   = cnt_q;
  assign acc         = in_valid_i && in_ready_o;
  assign fin         = acc && beat_q == 2'(BEATS-1);
  assign hs          = blk_valid_o && blk_ready_i;
  assign held_n      = 2'(buf_vld[0]) + 2'(buf_vld[1]) + 2'(fin) - 2'(hs);
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gath_d  = gath_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      gath_d  = '0;
      beat_d  = '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d = len_i == '0 ? IDLE : FILL;
        done_d  = len_i == '0;
        len_d   = len_i;
        cnt_d   = '0;
        gath_d  = '0;
        beat_d  = '0;
      end
    end else begin
      beat_d  = beat_q + 2'(acc);
      gath_d  = gath_q + CNT_W'(fin);
      cnt_d   = cnt_q + CNT_W'(hs);
      done_d  = hs && blk_last_o;
      state_d = done_d ? IDLE : held_n != 2'd0 ? HOLD : FILL;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      gath_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gath_q  <= gath_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_aes_block_gather.sv
// tb_aes_block_gather: randomized bench against a queue-based block model.
module tb_aes_block_gather;
  localparam int CNT_W = 16;
`ifdef AES_GATHER_SKID_EN
  localparam int NB = 2;
  localparam int SPAN = 15;
`else
  localparam int NB = 1;
  localparam int SPAN = 18;
`endif
  logic clk_i = 1'b0;
  logic rst_i, clear_i, start_i, in_valid_i, in_ready_o;
  logic blk_valid_o, blk_ready_i, blk_last_o, busy_o, done_o;
  logic [CNT_W-1:0] len_i, blk_cnt_o;
  logic [31:0]  in_data_i;
  logic [127:0] blk_data_o;
  int n_chk = 0, n_fail = 0;
  bit active, done_exp;
  int mlen, words, cnt_exp, stall, cyc, first_acc, last_acc;
  logic [127:0] partial, obs_hs;
  logic [127:0] exp_q[$];
  logic [31:0]  word_q[$];

  always #5 clk_i = ~clk_i;

  aes_block_gather #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .blk_last_o(blk_last_o), .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return active && (words / 4 < mlen) && (exp_q.size() < NB);
  endfunction

  task automatic model_reset();
    active = 0; words = 0; cnt_exp = 0; done_exp = 0; exp_q.delete();
  endtask

  // one clock: predict handshakes from the model, advance, then compare all outputs
  task automatic step();
    bit acc, hs;
    acc = in_valid_i && exp_ready();
    hs  = blk_ready_i && exp_q.size() > 0;
    if (hs) obs_hs = blk_data_o;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    cyc++;
    @(posedge clk_i); #1;
    done_exp = 0;
    if (clear_i) begin
      active = 0; words = 0; cnt_exp = 0; exp_q.delete();
    end else if (!active) begin
      if (start_i) begin
        cnt_exp = 0;
        if (len_i == 0) done_exp = 1;
        else begin active = 1; mlen = len_i; words = 0; end
      end
    end else begin
      if (acc) begin
        partial = {partial[95:0], in_data_i};
        words++;
        if (word_q.size() > 0) void'(word_q.pop_front());
        if (words % 4 == 0) exp_q.push_back(partial);
      end
      if (hs) begin
        void'(exp_q.pop_front());
        cnt_exp++;
        if (cnt_exp == mlen) begin active = 0; done_exp = 1; end
      end
    end
    check("busy", busy_o, active);
    check("in_ready", in_ready_o, exp_ready());
    check("blk_valid", blk_valid_o, exp_q.size() > 0);
    check("blk_last", blk_last_o, exp_q.size() > 0 && cnt_exp + 1 == mlen);
    check("done", done_o, done_exp);
    check("blk_cnt", blk_cnt_o, cnt_exp);
    if (exp_q.size() > 0) check("blk_data", blk_data_o, exp_q[0]);
  endtask

  task automatic drive(input int vmode, input int rmode);
    in_valid_i = vmode == 1 ? 1'b1 : ($urandom % 4 != 0);
    in_data_i  = word_q.size() > 0 ? word_q[0] : $urandom;
    start_i    = vmode == 1 && ($urandom % 8 == 0);
    len_i      = CNT_W'($urandom);
    if (rmode == 2) begin
      if (exp_q.size() > 0) begin
        blk_ready_i = stall >= 5;
        stall = blk_ready_i ? 0 : stall + 1;
      end else blk_ready_i = 1'b0;
    end else blk_ready_i = rmode == 1 ? 1'b1 : $urandom % 2;
  endtask

  task automatic run_job(input int l, input int vmode, input int rmode);
    start_i = 1; len_i = CNT_W'(l); in_valid_i = 0; blk_ready_i = 0; stall = 0;
    step();
    start_i = 0;
    for (int c = 0; c < 3000 && active; c++) begin
      drive(vmode, rmode);
      step();
    end
    start_i = 0; in_valid_i = 0; blk_ready_i = 0;
    check("job_end", active, 0);
  endtask

  initial begin
    rst_i = 1; clear_i = 0; start_i = 0; len_i = '0; in_data_i = '0;
    in_valid_i = 0; blk_ready_i = 0; partial = '0; obs_hs = '0;
    cyc = 0; first_acc = -1; last_acc = -1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_ready", in_ready_o, 0);
    check("rst_valid", blk_valid_o, 0);
    check("rst_data", blk_data_o, 0);
    check("rst_cnt", blk_cnt_o, 0);
    rst_i = 0;
    step();
    word_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    run_job(1, 1, 1);
    check("single_block", obs_hs, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("single_cnt", blk_cnt_o, 1);
    run_job(3, 0, 2);
    check("stall_cnt", blk_cnt_o, 3);
    run_job(0, 1, 1);
    step();
    start_i = 1; len_i = 2;
    step();
    start_i = 0;
    for (int c = 0; c < 50 && words < 2; c++) begin
      in_valid_i = 1; in_data_i = $urandom;
      step();
    end
    in_valid_i = 0; clear_i = 1;
    step();
    clear_i = 0;
    step();
    word_q = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    run_job(1, 1, 1);
    check("post_clear_block", obs_hs, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    start_i = 1; len_i = 1;
    step();
    start_i = 0;
    for (int c = 0; c < 50 && exp_q.size() == 0; c++) begin
      in_valid_i = 1; blk_ready_i = 0; in_data_i = $urandom;
      step();
    end
    in_valid_i = 0;
    check("pre_rst_valid", blk_valid_o, 1);
    rst_i = 1;
    #1;
    model_reset();
    check("mid_rst_valid", blk_valid_o, 0);
    check("mid_rst_last", blk_last_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_data", blk_data_o, 0);
    @(posedge clk_i); #1;
    check("mid_rst_done2", done_o, 0);
    rst_i = 0;
    step();
    run_job(1, 0, 0);
    for (int j = 0; j < 8; j++) run_job(1 + $urandom % 6, $urandom % 2, $urandom % 3);
    first_acc = -1;
    run_job(4, 1, 1);
    check("burst_span", last_acc - first_acc, SPAN);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_block_gather.md
AES_BLOCK_GATHER -- requirements
Module: aes_block_gather

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the block-count fields.
REQ-002 SHALL have ports clk_i in 1 (single clock) and rst_i in 1 (asynchronous reset, active-high).
REQ-003 SHALL have port clear_i in 1: synchronous abort/flush.
REQ-004 SHALL have ports start_i in 1 (job start pulse) and len_i in CNT_W (number of 128-bit blocks in the job).
REQ-005 SHALL have ports in_data_i in 32, in_valid_i in 1 and in_ready_o out 1: the 32-bit word stream from the streamer.
REQ-006 SHALL have ports blk_data_o out 128, blk_valid_o out 1, blk_ready_i in 1 and blk_last_o out 1: the block stream to the cipher core.
REQ-007 SHALL have ports busy_o out 1, done_o out 1 (one-cycle pulse) and blk_cnt_o out CNT_W (blocks delivered in the current job).

Function
REQ-008 SHALL implement states IDLE, FILL and HOLD.
REQ-009 In IDLE, start_i with len_i>0 SHALL latch len_i, zero the beat and block counters, and enter FILL on the next cycle.
REQ-010 In IDLE, start_i with len_i=0 SHALL pulse done_o on the next cycle and stay in IDLE.
REQ-011 start_i while busy SHALL be ignored.
REQ-012 Beat k (0..3) of a block SHALL occupy blk_data_o[127-32k -: 32]; the first beat is the most significant word.
REQ-013 A beat SHALL be accepted only when in_valid_i and in_ready_o are both high in the same cycle.
REQ-014 in_ready_o SHALL be high only in FILL with a free buffer slot.
REQ-015 in_ready_o SHALL NOT depend combinationally on in_valid_i.
REQ-016 On acceptance of the 4th beat the SHALL register the block, enter HOLD and raise blk_valid_o on the next cycle; latency from 4th beat to blk_valid_o is 1 cycle.
REQ-017 blk_valid_o and blk_data_o SHALL stay stable until blk_ready_i is seen high.
REQ-018 blk_last_o SHALL be high with blk_valid_o exactly when the held block is block len_i of the job.
REQ-019 On the block handshake, blk_cnt_o SHALL increment.
REQ-020 After a non-last block handshake the SHALL return to FILL; after the last block handshake it SHALL return to IDLE and pulse done_o in that same cycle.
REQ-021 busy_o SHALL be high in FILL and HOLD.
REQ-022 blk_cnt_o SHALL hold its final value until the next accepted start_i.
REQ-023 Beats arriving after the last block has been gathered SHALL NOT be accepted (in_ready_o low).
REQ-024 clear_i SHALL, in any state, discard partial and held blocks, zero the counters, deassert blk_valid_o and in_ready_o, and enter IDLE next cycle without pulsing done_o.
REQ-025 clear_i SHALL take priority over start_i and over any handshake in the same cycle.
REQ-026 The block counter SHALL be CNT_W bits wide, and the comparison against the latched len SHALL be an unsigned equality test.

Reset
REQ-027 rst_i high SHALL asynchronously force IDLE and zero all counters and data registers.
REQ-028 While rst_i is high, in_ready_o, blk_valid_o, blk_last_o, busy_o and done_o SHALL be 0, and blk_cnt_o and blk_data_o SHALL be 0.
REQ-029 Reset asserted mid-job SHALL drop the job with no done_o pulse.

Configuration
REQ-030 When macro AES_GATHER_SKID_EN is defined, a second 128-bit buffer SHALL let FILL continue while a block is held in HOLD.
REQ-031 With AES_GATHER_SKID_EN, in_ready_o SHALL fall only when both buffers are occupied, giving a sustained rate of 1 beat/cycle when blk_ready_i is held high.
REQ-032 With AES_GATHER_SKID_EN, block order SHALL be preserved.
REQ-033 Without AES_GATHER_SKID_EN, a single buffer SHALL be used and in_ready_o SHALL be low throughout HOLD.

Structure
REQ-034 The state enum, the beats-per-block constant (4) and the block width constant (128) SHALL live in aes_package.
REQ-035 One sub-module, aes_gather_buf (128-bit word-indexed load register with valid flag), SHALL be instantiated once, or twice with the skid option.

Verification
REQ-036 Reset then start with len=1, beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, blk_ready=1 -> blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF one cycle after the 4th beat, blk_last_o=1, done_o pulses, blk_cnt_o=1.
REQ-037 Start len=3 with blk_ready_i low for 5 cycles per block -> data stable while stalled, blk_last_o only on block 3, blk_cnt_o=3; without the skid option in_ready_o stays 0 during each stall.
REQ-038 Start len=0 -> done_o pulses one cycle later, busy_o stays 0, no block output.
REQ-039 clear_i after 2 beats of block 1 (len=2), then a new start len=1 -> the first output block is built only from post-clear beats and done_o fires once.
REQ-040 rst_i asserted while blk_valid_o is high -> all outputs 0 within the reset cycle with no done_o pulse, then a fresh len=1 job completes.
REQ-041 With AES_GATHER_SKID_EN, len=4 with continuous in_valid_i and blk_ready_i -> 16 beats accepted in 16 consecutive cycles.
